// File: rtl/comparador_serie.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serie
// Brief    : Bit-serial MSB-first magnitude comparator with early exit,
//            optional two's complement mode and examined-bit count.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serie #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          signo,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    output logic          busy,
    output logic          done,
    output logic          menor,
    output logic          igual,
    output logic          mayor,
    output logic [CW-1:0] ciclos
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARA = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_a, w_a_nxt;
    logic [N-1:0]  r_b, w_b_nxt;
    logic          r_signo, w_signo_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_menor, w_menor_nxt;
    logic          r_igual, w_igual_nxt;
    logic          r_mayor, w_mayor_nxt;
    logic [CW-1:0] r_ciclos, w_ciclos_nxt;

    logic          w_bit_a;
    logic          w_bit_b;
    logic          w_flip;

    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];
    // In signed mode the sign bit carries inverted weight, so the decision
    // flips only when the operands first differ at the MSB.
    assign w_flip  = r_signo && (r_idx == IW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signo  <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_menor  <= 1'b0;
            r_igual  <= 1'b0;
            r_mayor  <= 1'b0;
            r_ciclos <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_signo  <= w_signo_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_menor  <= w_menor_nxt;
            r_igual  <= w_igual_nxt;
            r_mayor  <= w_mayor_nxt;
            r_ciclos <= w_ciclos_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_signo_nxt  = r_signo;
        w_idx_nxt    = r_idx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_menor_nxt  = r_menor;
        w_igual_nxt  = r_igual;
        w_mayor_nxt  = r_mayor;
        w_ciclos_nxt = r_ciclos;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_nxt      = A;
                    w_b_nxt      = B;
                    w_signo_nxt  = signo;
                    w_idx_nxt    = IW'(N - 1);
                    w_menor_nxt  = 1'b0;
                    w_igual_nxt  = 1'b0;
                    w_mayor_nxt  = 1'b0;
                    w_ciclos_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = COMPARA;
                end
            end
            COMPARA: begin
                w_ciclos_nxt = r_ciclos + CW'(1);
                if (w_bit_a != w_bit_b) begin
                    w_mayor_nxt = w_bit_a ^ w_flip;
                    w_menor_nxt = ~(w_bit_a ^ w_flip);
                    w_igual_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_idx == '0) begin
                    w_igual_nxt = 1'b1;
                    w_menor_nxt = 1'b0;
                    w_mayor_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx - IW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign menor  = r_menor;
    assign igual  = r_igual;
    assign mayor  = r_mayor;
    assign ciclos = r_ciclos;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serie.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_serie
// Brief    : Directed vector bench for comparador_serie (N = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_serie;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset;
    logic          start;
    logic          signo;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic          menor;
    logic          igual;
    logic          mayor;
    logic [CW-1:0] ciclos;

    int n_checks;
    int n_fail;

    comparador_serie #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .signo  (signo),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .menor  (menor),
        .igual  (igual),
        .mayor  (mayor),
        .ciclos (ciclos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [2:0] flags;   // {menor, igual, mayor}
        int         cic;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int flags_now();
        return int'({menor, igual, mayor});
    endfunction

    // Waits (on negedges) until done is seen or the limit expires.
    task automatic wait_done(input string name, input int limit, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
    endtask

    // Issues one start, checks the cleared/busy state, waits for the result.
    task automatic do_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [2:0] flags, input int cic);
        int lat;
        @(negedge clk);
        A = a; B = b; signo = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_flags_clr"}, flags_now(), 0);
        wait_done(name, N + 4, lat);
        chk({name, "_latency"}, lat, cic);
        chk({name, "_flags"}, flags_now(), int'(flags));
        chk({name, "_ciclos"}, int'(ciclos), cic);
        chk({name, "_busy_low"}, int'(busy), 0);
        @(negedge clk);
        chk({name, "_done_1cyc"}, int'(done), 0);
        chk({name, "_flags_hold"}, flags_now(), int'(flags));
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int seen;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'h07, 8'h04, 1'b0, 3'b001, 7};
        vecs[1] = '{8'h07, 8'h07, 1'b0, 3'b010, 8};
        vecs[2] = '{8'h07, 8'h8A, 1'b0, 3'b100, 1};
        vecs[3] = '{8'h07, 8'h8A, 1'b1, 3'b001, 1};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 3'b100, 3};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 3'b001, 8};
        vecs[6] = '{8'h80, 8'h00, 1'b1, 3'b100, 1};
        vecs[7] = '{8'hFF, 8'h01, 1'b1, 3'b100, 1};
        vecs[8] = '{8'hFE, 8'hFF, 1'b1, 3'b100, 8};
        vecs[9] = '{8'h7F, 8'h80, 1'b0, 3'b100, 1};

        // Reset state and idle hold
        reset = 1'b1; start = 1'b0; signo = 1'b0; A = '0; B = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", flags_now(), 0);
        chk("rst_ciclos", int'(ciclos), 0);
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_flags", flags_now(), 0);
        chk("idle_ciclos", int'(ciclos), 0);

        for (int i = 0; i < 10; i++) begin
            do_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].flags, vecs[i].cic);
        end

        // Result stability long after done
        do_cmp("stab", 8'h07, 8'h04, 1'b0, 3'b001, 7);
        repeat (10) @(negedge clk);
        chk("stab_flags", flags_now(), 3'b001);
        chk("stab_ciclos", int'(ciclos), 7);

        // Reset mid-comparison aborts with no done pulse
        @(negedge clk);
        A = 8'h55; B = 8'h55; signo = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_flags", flags_now(), 0);
        chk("midrst_ciclos", int'(ciclos), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        chk("midrst_flags_after", flags_now(), 0);
        do_cmp("postrst", 8'h10, 8'h20, 1'b0, 3'b100, 3);

        // start while busy is ignored, including new operands
        @(negedge clk);
        A = 8'h01; B = 8'h00; signo = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'hFF; B = 8'h00; signo = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", N + 4, lat);
        chk("ign_latency", lat + 3, 8);
        chk("ign_flags", flags_now(), 3'b001);
        chk("ign_ciclos", int'(ciclos), 8);

        // Back-to-back: start held through the done cycle
        do_cmp("b2b_first", 8'h01, 8'h00, 1'b0, 3'b001, 8);
        @(negedge clk);
        A = 8'h01; B = 8'h00; signo = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done("b2b", N + 4, lat);
        A = 8'h80; B = 8'h00; signo = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_done_low", int'(done), 0);
        chk("b2b_flags_clr", flags_now(), 0);
        chk("b2b_ciclos_clr", int'(ciclos), 0);
        @(negedge clk);
        chk("b2b_done", int'(done), 1);
        chk("b2b_flags", flags_now(), 3'b001);
        chk("b2b_ciclos", int'(ciclos), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparador_serie.md
Name: comparador_serie

Overview:
- Parametrised, sequential successor of the combinational 4-bit comparador; it takes the same menor/igual/mayor result flags.
- Compares two N-bit operands bit-serially, MSB first, one bit per clock, with start/busy/done handshake.
- Terminates early at the first differing bit.
- Adds a signed (two's complement) mode and reports the number of bits examined.
- Used where a narrow, area-cheap comparator is acceptable and the caller can wait up to N cycles.

Parameters:
N, 8, operand width in bits; legal range N >= 2.
CW, $clog2(N+1), width of ciclos; derived, not overridden.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a comparison; sampled only in IDLE
signo  input  1  1 = operands are two's complement, 0 = unsigned; latched with start
A  input  N  operand A; latched with start
B  input  N  operand B; latched with start
busy  output  1  comparison in progress
done  output  1  one-cycle pulse: result flags valid and updated
menor  output  1  A < B
igual  output  1  A == B
mayor  output  1  A > B
ciclos  output  CW  bits examined in the last comparison, 1..N

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy, done, menor, igual, mayor and ciclos all go to 0.
  - Latched operands are don't-care.
- States: IDLE, COMPARA.
- IDLE:
  - On a rising edge with start=1: latch A, B and signo; set bit index idx=N-1; clear menor/igual/mayor/ciclos; set busy=1; go to COMPARA.
  - start=0: remain in IDLE; outputs hold.
- COMPARA, per edge, examines bit idx of the latched operands (a=A_l[idx], b=B_l[idx]) and increments ciclos:
  - a != b: decision. Flip is 1 when signo_l=1 and idx=N-1, else 0. mayor = a XOR flip; menor = NOT mayor; igual = 0. Assert done, clear busy, go to IDLE.
  - a == b and idx == 0: igual=1, menor=mayor=0. Assert done, clear busy, go to IDLE.
  - a == b and idx > 0: idx decrements; stay in COMPARA.
- Latency:
  - If start is sampled at edge k and the highest differing bit is i, the decision edge is k+(N-i) and ciclos=N-i.
  - Equal operands: decision edge k+N, ciclos=N.
  - done is high for exactly the one cycle following the decision edge.
- busy is high from edge k through the decision edge, then low.
- Flags and ciclos are registered. They hold their value after done until the next accepted start clears them.
- Exactly one of menor/igual/mayor is 1 after any completed comparison. All three are 0 after reset or while busy.
- start while busy=1 is ignored. A, B and signo changes while busy are ignored, because the latched copies are used.
- Back-to-back operation: start asserted during the done cycle (state IDLE) is accepted at the next edge. That edge clears the flags and sets busy.
- Reset mid-comparison: the comparison aborts. No done pulse is produced and the flags stay 0. The next start after reset is serviced normally.
- No wrap-around: idx never decrements below 0. COMPARA always exits by bit 0.

Test Plan:
1. Reset: assert reset for 1 cycle, clk running -> busy=done=menor=igual=mayor=0, ciclos=0. Hold start=0 for 5 cycles -> outputs unchanged.
2. Unsigned, N=8: A=0x07, B=0x04, signo=0, start for 1 cycle -> busy=1 for 7 edges; done pulses once; mayor=1, menor=igual=0, ciclos=7. Flags remain stable 10 cycles later.
3. Equal operands: A=B=0x07, start -> done after 8 cycles; igual=1, menor=mayor=0, ciclos=8.
4. Signed vs unsigned: A=0x07, B=0x8A.
   - signo=0 -> done after 1 cycle, menor=1, ciclos=1.
   - Repeat with signo=1 -> done after 1 cycle, mayor=1, ciclos=1.
5. Reset mid-operation: A=B=0x55, start; assert reset 3 cycles later -> immediately busy=0 and all flags 0, with no done. Then A=0x10, B=0x20, start -> menor=1, ciclos=3.
6. Handshake:
   - During a busy comparison of A=0x01, B=0x00 (ciclos should reach 8), pulse start again with A=0xFF, B=0x00 -> ignored; result mayor=1, ciclos=8.
   - Hold start=1 through the done cycle with A=0x80, B=0x00 -> new comparison begins on the next edge; flags clear, then mayor=1, ciclos=1.
